// File: rtl/muldiv_sequencer_if.sv
// Handshake and HI/LO bus between the EX stage and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] rs;
  logic [DATA_W-1:0] rt;
  logic              flush;
  logic              wr_hi;
  logic              wr_lo;
  logic [DATA_W-1:0] wr_data;
  logic              ready;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, rs, rt, flush, wr_hi, wr_lo, wr_data,
    input  ready, busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, flush, wr_hi, wr_lo, wr_data,
    output ready, busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative mult/multu/div/divu sequencer owning HI/LO; one shift-add or
// restoring-divide step per cycle on magnitudes, sign fix-up in a final cycle.
module muldiv_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  muldiv_sequencer_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] wrk_q, wrk_d;
  logic [DATA_W-1:0] m_q, m_d;

  logic signed [DATA_W-1:0] rs_s, rt_s;
  logic                     signed_op;
  logic [DATA_W:0]          mul_sum;
  logic [DATA_W:0]          div_shift;
  logic [DATA_W-1:0]        div_rem;
  logic                     div_ge;
  logic [2*DATA_W-1:0]      prod_fix;

  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] x,
                                            input logic en);
    return (en && x[DATA_W-1]) ? DATA_W'(-x) : DATA_W'(x);
  endfunction

  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] x,
                                                 input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  assign rs_s      = bus.rs;
  assign rt_s      = bus.rt;
  assign signed_op = ~bus.op[0];

  // Multiply: {acc,wrk} shifts right, adding the multiplicand when the LSB is set.
  // Divide: {acc,wrk} shifts left, subtracting the divisor when it fits.
  assign mul_sum   = {1'b0, acc_q} + {1'b0, (wrk_q[0] ? m_q : {DATA_W{1'b0}})};
  assign div_shift = {acc_q, wrk_q[DATA_W-1]};
  assign div_ge    = (div_shift >= {1'b0, m_q});
  assign div_rem   = div_shift[DATA_W-1:0] - m_q;
  assign prod_fix  = neg_2w({acc_q, wrk_q}, neg_res_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    wrk_d     = wrk_q;
    m_d       = m_q;
    case (state_q)
      IDLE: begin
        if (bus.wr_hi) hi_d = bus.wr_data;
        if (bus.wr_lo) lo_d = bus.wr_data;
        if (bus.start) begin
          state_d   = CALC;
          busy_d    = 1'b1;
          cnt_d     = '0;
          dz_d      = 1'b0;
          is_div_d  = bus.op[1];
          neg_res_d = signed_op & (rs_s[DATA_W-1] ^ rt_s[DATA_W-1]);
          neg_rem_d = signed_op & bus.op[1] & rs_s[DATA_W-1];
          m_d       = mag(rt_s, signed_op);
          wrk_d     = mag(rs_s, signed_op);
          acc_d     = '0;
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) begin
            acc_d = div_ge ? div_rem : div_shift[DATA_W-1:0];
            wrk_d = {wrk_q[DATA_W-2:0], div_ge};
          end else begin
            acc_d = mul_sum[DATA_W:1];
            wrk_d = {mul_sum[0], wrk_q[DATA_W-1:1]};
          end
          if (cnt_q == CNT_W'(DATA_W-1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // A zero divisor leaves the dividend magnitude in acc, so the
            // normal remainder sign fix-up restores rs exactly.
            dz_d = (m_q == '0);
            lo_d = (m_q == '0) ? {DATA_W{1'b1}} : neg_w(wrk_q, neg_res_q);
            hi_d = neg_w(acc_q, neg_rem_q);
          end else begin
            hi_d = prod_fix[2*DATA_W-1:DATA_W];
            lo_d = prod_fix[DATA_W-1:0];
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    is_div_q  <= is_div_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
    acc_q     <= acc_d;
    wrk_q     <= wrk_d;
    m_q       <= m_d;
  end

  assign bus.ready    = ~busy_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomized bench for muldiv_sequencer against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_sequencer_if #(.DATA_W(W)) bus ();

  muldiv_sequencer #(.DATA_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // HI/LO as the architecture defines them, from 64-bit integer arithmetic.
  function automatic void model(input logic [1:0] op, input logic [31:0] rs,
                                input logic [31:0] rt, output logic [31:0] h,
                                output logic [31:0] l, output logic dz);
    longint          a, b, q, r;
    longint unsigned pu;
    dz = 1'b0;
    case (op)
      2'b00: begin
        a = longint'($signed(rs)) * longint'($signed(rt));
        {h, l} = a;
      end
      2'b01: begin
        pu = 64'(rs) * 64'(rt);
        {h, l} = pu;
      end
      default: begin
        if (rt == 32'h0) begin
          l  = 32'hFFFF_FFFF;
          h  = rs;
          dz = 1'b1;
        end else begin
          if (op == 2'b10) begin
            a = longint'($signed(rs));
            b = longint'($signed(rt));
          end else begin
            a = longint'({32'h0, rs});
            b = longint'({32'h0, rt});
          end
          q = a / b;
          r = a % b;
          l = q[31:0];
          h = r[31:0];
        end
      end
    endcase
  endfunction

  task automatic launch(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs    = rs;
    bus.rt    = rt;
    tick();
    bus.start = 1'b0;
    check("accept busy", bus.busy, 1'b1);
    check("accept ready", bus.ready, 1'b0);
    check("accept done", bus.done, 1'b0);
  endtask

  task automatic await_done(input string tag, input logic [31:0] eh, input logic [31:0] el,
                            input logic edz, input int elapsed);
    logic [31:0] h0, l0;
    int          n;
    bit          got;
    h0  = bus.hi;
    l0  = bus.lo;
    n   = elapsed;
    got = 1'b0;
    while (n < 2 * W && !got) begin
      tick();
      n++;
      if (bus.done) got = 1'b1;
      else begin
        check({tag, " busy"}, bus.busy, 1'b1);
        check({tag, " hold"}, {bus.hi, bus.lo}, {h0, l0});
      end
    end
    check({tag, " latency"}, 64'(n), 64'(W + 1));
    check({tag, " hi"}, bus.hi, eh);
    check({tag, " lo"}, bus.lo, el);
    check({tag, " div_zero"}, bus.div_zero, edz);
    check({tag, " busy end"}, bus.busy, 1'b0);
    check({tag, " ready end"}, bus.ready, 1'b1);
    tick();
    check({tag, " done pulse"}, bus.done, 1'b0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] rs, rt, eh, el, lo_before;
    logic        edz;

    bus.start = 1'b0; bus.op = 2'b00; bus.rs = '0; bus.rt = '0;
    bus.flush = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0;
    rst_n = 1'b0;
    tick();
    tick();
    check("reset hi", bus.hi, 32'h0);
    check("reset lo", bus.lo, 32'h0);
    check("reset busy", bus.busy, 1'b0);
    check("reset ready", bus.ready, 1'b1);
    check("reset done", bus.done, 1'b0);
    check("reset div_zero", bus.div_zero, 1'b0);
    rst_n = 1'b1;

    launch(2'b00, 32'd7, 32'hFFFF_FFFD);
    await_done("mult 7*-3", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    await_done("multu max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    await_done("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    launch(2'b11, 32'h8000_0000, 32'd0);
    await_done("divu by 0", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    tick();
    check("div_zero held", bus.div_zero, 1'b1);
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_zero cleared", bus.div_zero, 1'b0);
    await_done("div overflow", 32'h0, 32'h8000_0000, 1'b0, 0);
    launch(2'b10, 32'hFFFF_FFF0, 32'd0);
    await_done("div -16 by 0", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 0);

    // Start arriving mid-multiply must be dropped.
    launch(2'b00, 32'd9, 32'd7);
    repeat (9) tick();
    bus.start = 1'b1; bus.op = 2'b11; bus.rs = 32'd100; bus.rt = 32'd7;
    tick();
    bus.start = 1'b0;
    await_done("start while busy", 32'h0, 32'd63, 1'b0, 10);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no second done", bus.done, 1'b0);
      check("no queued op", bus.busy, 1'b0);
    end

    bus.wr_hi = 1'b1; bus.wr_data = 32'h1234;
    tick();
    bus.wr_hi = 1'b0;
    check("mthi idle", bus.hi, 32'h1234);
    lo_before = bus.lo;
    launch(2'b00, 32'd3, 32'd4);
    repeat (3) tick();
    bus.wr_hi = 1'b1; bus.wr_data = 32'hDEAD;
    tick();
    bus.wr_hi = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush busy", bus.busy, 1'b0);
    check("flush ready", bus.ready, 1'b1);
    check("flush done", bus.done, 1'b0);
    check("flush hi", bus.hi, 32'h1234);
    check("flush lo", bus.lo, lo_before);

    // Flush in IDLE does not block start; mtlo on the accept edge still lands.
    bus.flush = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'h5555;
    launch(2'b01, 32'd5, 32'd6);
    bus.flush = 1'b0; bus.wr_lo = 1'b0;
    check("mtlo with start", bus.lo, 32'h5555);
    await_done("multu after flush", 32'h0, 32'd30, 1'b0, 0);

    launch(2'b00, 32'h0001_2345, 32'h0000_0777);
    repeat (19) tick();
    rst_n = 1'b0;
    tick();
    check("midop reset hi", bus.hi, 32'h0);
    check("midop reset lo", bus.lo, 32'h0);
    check("midop reset busy", bus.busy, 1'b0);
    check("midop reset done", bus.done, 1'b0);
    rst_n = 1'b1;
    launch(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    await_done("mult min*-1", 32'h0, 32'h8000_0000, 1'b0, 0);

    for (int k = 0; k < 24; k++) begin
      op = 2'($urandom_range(0, 3));
      rs = $urandom;
      rt = $urandom;
      if ($urandom_range(0, 3) == 0) rt = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) rt = 32'h0;
      if ($urandom_range(0, 9) == 0) begin rs = 32'h8000_0000; rt = 32'hFFFF_FFFF; end
      model(op, rs, rt, eh, el, edz);
      launch(op, rs, rt);
      await_done($sformatf("rand op%0d %h,%h", op, rs, rt), eh, el, edz, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
